// File: rtl/ask_demodulator.sv
// ASK demodulator: integrates |ASK| over SAMPLES_PER_BIT accepted samples per bit,
// thresholds the energy, and drops carrier lock after MAX_ZEROS consecutive 0-bits.
module ask_demodulator #(
    parameter int SAMPLES_PER_BIT = 1024,
    parameter int MAX_ZEROS       = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [15:0] ASK,
    input  logic               sample_valid,
    input  logic        [15:0] mag_threshold,
    input  logic        [31:0] energy_threshold,
    output logic               data,
    output logic               data_valid,
    output logic               locked,
    output logic        [31:0] energy
);

    typedef enum logic {SEARCH, TRACK} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(SAMPLES_PER_BIT - 1);
    localparam logic [7:0]  ZERO_LIMIT = 8'(MAX_ZEROS);

    state_t      state, state_next;
    logic [31:0] acc;
    logic [15:0] count;
    logic [7:0]  zero_run;

    logic [15:0] mag;
    logic [32:0] sum_wide;
    logic [31:0] sum_sat;
    logic [7:0]  zero_inc;
    logic        trigger;
    logic        final_sample;
    logic        bit_decision;
    logic        drop_lock;

    // Two's-complement negate in 16 bits maps -32768 to 0x8000 = 32768 unsigned.
    assign mag      = ASK[15] ? (16'(~ASK) + 16'd1) : 16'(ASK);
    assign sum_wide = {1'b0, acc} + {17'd0, mag};
    assign sum_sat  = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
    assign zero_inc = (zero_run == 8'hFF) ? zero_run : zero_run + 8'd1;

    assign trigger      = (state == SEARCH) && sample_valid && (mag >= mag_threshold);
    assign final_sample = (state == TRACK) && sample_valid && (count == LAST_COUNT);
    assign bit_decision = (sum_sat >= energy_threshold);
    assign drop_lock    = final_sample && !bit_decision && (zero_inc == ZERO_LIMIT);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= SEARCH;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: a default assignment up front keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            SEARCH: if (trigger)   state_next = TRACK;
            TRACK:  if (drop_lock) state_next = SEARCH;
            default:               state_next = SEARCH;
        endcase
    end

    // Output logic: lock indication depends on the state register only.
    always_comb begin
        locked = (state == TRACK);
    end

    // Integration, bit decision and zero-run tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            count      <= '0;
            zero_run   <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            energy     <= '0;
        end else begin
            data_valid <= 1'b0;
            if (trigger) begin
                acc   <= {16'd0, mag};
                count <= 16'd1;
            end else if (final_sample) begin
                data       <= bit_decision;
                energy     <= sum_sat;
                data_valid <= 1'b1;
                acc        <= '0;
                count      <= '0;
                if (bit_decision || drop_lock) zero_run <= '0;
                else                           zero_run <= zero_inc;
            end else if ((state == TRACK) && sample_valid) begin
                acc   <= sum_sat;
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ask_demodulator.sv
// Self-checking bench for ask_demodulator: directed scenarios plus randomized
// samples, compared every cycle against a queue-based per-bit reference model.
module tb_ask_demodulator;

    localparam int SPB  = 8;
    localparam int MAXZ = 3;

    logic               clock;
    logic               reset;
    logic signed [15:0] ask;
    logic               sample_valid;
    logic        [15:0] mag_threshold;
    logic        [31:0] energy_threshold;
    logic               data;
    logic               data_valid;
    logic               locked;
    logic        [31:0] energy;

    ask_demodulator #(.SAMPLES_PER_BIT(SPB), .MAX_ZEROS(MAXZ)) dut (
        .clock           (clock),
        .reset           (reset),
        .ASK             (ask),
        .sample_valid    (sample_valid),
        .mag_threshold   (mag_threshold),
        .energy_threshold(energy_threshold),
        .data            (data),
        .data_valid      (data_valid),
        .locked          (locked),
        .energy          (energy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a lock flag, the magnitudes collected for the current bit,
    // and the count of consecutive 0-bits.
    bit      m_locked;
    int      m_bit_mags[$];
    int      m_zeros;
    bit      exp_data;
    bit      exp_dv;
    longint  exp_energy;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked   = 0;
        m_bit_mags.delete();
        m_zeros    = 0;
        exp_data   = 0;
        exp_dv     = 0;
        exp_energy = 0;
    endtask

    task automatic model_sample(input int a, input bit v);
        int     m;
        longint total;
        exp_dv = 0;
        if (!v) return;
        m = (a < 0) ? -a : a;
        if (!m_locked) begin
            if (m >= int'(mag_threshold)) begin
                m_locked = 1;
                m_bit_mags.delete();
                m_bit_mags.push_back(m);
            end
            return;
        end
        m_bit_mags.push_back(m);
        if (m_bit_mags.size() == SPB) begin
            total = 0;
            foreach (m_bit_mags[i]) total += m_bit_mags[i];
            if (total > 64'hFFFF_FFFF) total = 64'hFFFF_FFFF;
            exp_energy = total;
            exp_data   = (total >= longint'(energy_threshold));
            exp_dv     = 1;
            m_bit_mags.delete();
            if (exp_data) m_zeros = 0;
            else if (m_zeros < 255) m_zeros++;
            if (m_zeros == MAXZ) begin
                m_locked = 0;
                m_zeros  = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".locked"},     locked,     m_locked);
        check({tag, ".data_valid"}, data_valid, exp_dv);
        check({tag, ".data"},       data,       exp_data);
        check({tag, ".energy"},     energy,     exp_energy);
    endtask

    // One clock: apply inputs, update the model for the edge, check #1 after it.
    task automatic step(input int a, input bit v, input string tag);
        ask          = 16'(a);
        sample_valid = v;
        @(posedge clock);
        model_sample(a, v);
        #1;
        check_outputs(tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    int r;
    int a;

    initial begin
        reset            = 1'b0;
        ask              = '0;
        sample_valid     = 1'b0;
        mag_threshold    = 16'd1000;
        energy_threshold = 32'd40000;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        // Silence never locks.
        for (int i = 0; i < 100; i++) step(0, 1, "silence");

        // Continuous carrier: four 1-bits of energy 64000.
        for (int i = 0; i < 4 * SPB; i++) step((i % 2) ? -8000 : 8000, 1, "carrier");

        // A 1-bit then a 0-bit, lock held.
        for (int i = 0; i < SPB; i++) step((i % 2) ? -8000 : 8000, 1, "one_zero_a");
        for (int i = 0; i < SPB; i++) step(0, 1, "one_zero_b");

        // A 1-bit then three 0-bits: third 0 drops lock; later silence stays in SEARCH.
        for (int i = 0; i < SPB; i++)     step(8000, 1, "drop_one");
        for (int i = 0; i < 3 * SPB; i++) step(0, 1, "drop_zeros");
        for (int i = 0; i < 10; i++)      step(0, 1, "drop_after");

        // Full-scale negative: energy 262144, contiguous then with gaps.
        for (int i = 0; i < SPB; i++)     step(-32768, 1, "fullscale");
        for (int i = 0; i < 2 * SPB; i++) step(-32768, (i % 2) == 0, "fullscale_gap");

        // Energy threshold boundary: exactly 40000 is a 1, 39999 is a 0.
        for (int i = 0; i < SPB; i++) step(5000, 1, "eth_eq");
        for (int i = 0; i < SPB; i++) step((i == SPB - 1) ? 4999 : -5000, 1, "eth_below");

        // Reset mid-bit discards the partial bit; a fresh 8-sample bit follows.
        pulse_reset("reset_pre");
        for (int i = 0; i < 5; i++)   step(8000, 1, "mid_a");
        pulse_reset("reset_mid");
        for (int i = 0; i < 3; i++)   step(0, 1, "mid_idle");
        for (int i = 0; i < SPB; i++) step(-8000, 1, "mid_fresh");

        // Magnitude threshold boundary in SEARCH.
        pulse_reset("reset_mth");
        step(999, 1, "mth_999");
        step(-999, 1, "mth_m999");
        step(-1000, 1, "mth_m1000");

        // Randomized samples, gaps, thresholds near the 8000-per-sample scale.
        pulse_reset("reset_rand");
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 25)      a = 0;
            else if (r < 45) a = int'($urandom_range(0, 1999)) - 1000;
            else if (r < 50) a = -32768;
            else             a = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 199) == 0) begin
                energy_threshold = 32'($urandom_range(20000, 150000));
                mag_threshold    = 16'($urandom_range(500, 3000));
            end
            if ($urandom_range(0, 999) == 0) pulse_reset("rand_reset");
            step(a, $urandom_range(0, 3) != 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ask_demodulator.md
ASK_DEMODULATOR -- requirements
Module: ask_demodulator

Interface
REQ-001 SHALL have parameter SAMPLES_PER_BIT, default 1024, samples integrated per bit decision (legal 2..65535).
REQ-002 SHALL have parameter MAX_ZEROS, default 8, consecutive 0-bit decisions that drop lock (legal 1..255).
REQ-003 SHALL have port clock  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port ASK  input  16  signed ASK sample from the modulator.
REQ-006 SHALL have port sample_valid  input  1  ASK accepted on an edge where sample_valid=1.
REQ-007 SHALL have port mag_threshold  input  16  unsigned; carrier-detect magnitude in SEARCH.
REQ-008 SHALL have port energy_threshold  input  32  unsigned; per-bit energy decision level.
REQ-009 SHALL have port data  output  1  demodulated bit, registered.
REQ-010 SHALL have port data_valid  output  1  one-cycle strobe, new data.
REQ-011 SHALL have port locked  output  1  high while state = TRACK.
REQ-012 SHALL have port energy  output  32  last completed bit accumulator value, registered.

Function
REQ-013 SHALL compute magnitude mag = |ASK| as 16-bit unsigned; -32768 -> 32768, no overflow.
REQ-014 SHALL implement two states: SEARCH, TRACK; reset state SEARCH.
REQ-015 In SEARCH, accepted sample with mag >= mag_threshold SHALL move to TRACK, load acc = mag, sample count = 1.
REQ-016 In SEARCH, samples below mag_threshold SHALL be discarded; acc held at 0.
REQ-017 In TRACK, each accepted sample SHALL add mag to 32-bit acc, saturating at 0xFFFFFFFF, and increment count.
REQ-018 The accepted sample that makes count = SAMPLES_PER_BIT SHALL be the bit's final sample; on that edge: data <= (acc+mag >= energy_threshold), energy <= acc+mag (saturated), data_valid <= 1, acc <= 0, count <= 0.
REQ-019 Latency: data/data_valid/energy SHALL be visible the cycle after the edge accepting the final sample; data_valid high exactly one cycle.
REQ-020 energy_threshold SHALL be sampled only at the decision edge; mag_threshold only in SEARCH.
REQ-021 sample_valid=0 SHALL freeze acc, count, state; data_valid 0 that cycle.
REQ-022 A zero-run counter SHALL increment on each 0 decision, clear on each 1 decision, saturating at 255.
REQ-023 A decision making the zero-run equal MAX_ZEROS SHALL still emit its bit (data_valid=1, data=0) and move to SEARCH on the same edge; zero-run cleared.
REQ-024 Re-entry to TRACK from SEARCH SHALL restart bit timing at the triggering sample (count = 1).
REQ-025 If the SEARCH->TRACK trigger and a decision are never simultaneous (exclusive states), no priority rule needed; any other simultaneous event SHALL follow REQ-018/023 ordering: decision first, then state change.
REQ-026 locked SHALL be combinational from the state register only (state == TRACK).

Reset
REQ-027 reset=0 SHALL asynchronously force state SEARCH, acc 0, count 0, zero-run 0, data 0, data_valid 0, locked 0, energy 0.
REQ-028 Reset asserted mid-bit SHALL discard the partial accumulation; no data_valid emitted for it.
REQ-029 Release of reset SHALL take effect on the next rising clock edge; first edge after release may accept a sample.

Verification (bench uses SAMPLES_PER_BIT=8, MAX_ZEROS=3, mag_threshold=1000, energy_threshold=40000)
REQ-030 Constant ASK=0, sample_valid=1 for 100 cycles -> locked=0, data_valid never 1, energy=0.
REQ-031 ASK alternating +8000/-8000 continuous -> locked=1 after first sample; data_valid every 8 samples, data=1, energy=64000.
REQ-032 8 samples at +/-8000 then 8 samples at 0 (trigger aligned) -> bits 1 then 0; energy 64000 then 0; locked stays 1.
REQ-033 One 1-bit then three 0-bits -> third 0 emitted with data_valid=1, locked falls same edge; 0-samples afterward leave SEARCH.
REQ-034 ASK=-32768 for 8 samples -> energy=262144, data=1; sample_valid toggled 1/0 each cycle -> decision after 16 cycles, same values.
REQ-035 reset=0 pulse after 5 samples of a bit -> all outputs 0 immediately, locked=0; after release, next trigger sample starts a fresh 8-sample bit.
